// File: rtl/mdlu_iterative_if.sv
// Issue/result bundle between execute-stage control and the multiply/divide unit.
interface mdlu_iterative_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       mdluOp;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, mdluOp, opA, opB, input busy, done, hi, lo);
    modport slave  (input start, mdluOp, opA, opB, output busy, done, hi, lo);
endinterface

// File: rtl/mdlu_iterative.sv
// Iterative signed multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide on operand magnitudes, signs applied in a final fix-up cycle.
module mdlu_iterative #(
    parameter int WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    mdlu_iterative_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_ZERO = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
    logic [WIDTH-1:0]   opnd, abs_a, abs_b, hi_r, lo_r, hi_fix, lo_fix, div_rem;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               is_div, neg_q, neg_r, div_zero, done_r, div_ge, issue;

    assign issue   = bus.start && (bus.mdluOp == OP_MULT || bus.mdluOp == OP_DIV);
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (counter == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Magnitudes stay unsigned W-bit, so |INT_MIN| = 2^(W-1) is exact.
    always_comb begin
        abs_a     = bus.opA[WIDTH-1] ? -bus.opA : bus.opA;
        abs_b     = bus.opB[WIDTH-1] ? -bus.opB : bus.opB;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_shift[WIDTH-1:0] - opnd;
        if (is_div)
            acc_next = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        prod_fix = neg_q ? -acc : acc;
        if (is_div) begin
            lo_fix = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            hi_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            lo_fix = prod_fix[WIDTH-1:0];
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // acc holds {partial product | remainder, multiplier | quotient}.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter  <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        counter  <= '0;
                        is_div   <= (bus.mdluOp == OP_DIV);
                        neg_q    <= bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1];
                        neg_r    <= bus.opA[WIDTH-1];
                        div_zero <= (bus.opB == '0);
                        if (bus.mdluOp == OP_DIV) begin
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                            opnd <= abs_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                            opnd <= abs_a;
                        end
                    end else if (bus.start && bus.mdluOp == OP_ZERO) begin
                        hi_r   <= '0;
                        lo_r   <= '0;
                        done_r <= 1'b1;
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    acc     <= acc_next;
                end
                FIX: begin
                    hi_r   <= hi_fix;
                    lo_r   <= lo_fix;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdlu_iterative.sv
// Bench for mdlu_iterative: cycle model built on host integer arithmetic,
// per-cycle compare, plus literal expectations for the directed cases.
module tb_mdlu_iterative;
    localparam int W = 32;
    localparam logic [W-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [W-1:0] INT_MAX = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdlu_iterative_if #(.WIDTH(W)) bus();
    mdlu_iterative #(.WIDTH(W)) dut (.clock(clk), .reset(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Reference result straight from signed 64-bit arithmetic.
    function automatic logic [2*W-1:0] golden(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'd0) return sa * sb;
        if (b == '0) return {a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    logic           m_busy, m_done;
    logic [W-1:0]   m_hi, m_lo;
    logic [2*W-1:0] p_res;
    int             left;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; left <= 0; p_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (left > 0) begin
                left <= left - 1;
                if (left == 1) begin
                    m_hi <= p_res[2*W-1:W]; m_lo <= p_res[W-1:0];
                    m_done <= 1'b1; m_busy <= 1'b0;
                end
            end else if (bus.start) begin
                case (bus.mdluOp)
                    2'd0, 2'd1: begin
                        p_res <= golden(bus.mdluOp, bus.opA, bus.opB);
                        left <= W + 1; m_busy <= 1'b1;
                    end
                    2'd2: begin m_hi <= '0; m_lo <= '0; m_done <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== {m_busy, m_done, m_hi, m_lo}) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t busy=%b exp %b done=%b exp %b hi=%h exp %h lo=%h exp %h",
                     $time, bus.busy, m_busy, bus.done, m_done, bus.hi, m_hi, bus.lo, m_lo);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.mdluOp = op; bus.opA = a; bus.opB = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.opA = $urandom; bus.opB = $urandom;
        bus.mdluOp = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        bit found = 0;
        cyc = 0; busy_cnt = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) found = 1;
        end
        if (!found) begin
            tests++; fails++;
            $display("FAIL done_timeout got no done within %0d cycles expected done", cyc);
        end
    endtask

    int cyc, bc;

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.mdluOp = 2'd0; bus.opA = '0; bus.opB = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", bus.hi, '0);
        chk("reset_lo", bus.lo, '0);
        chk("reset_busy", W'(bus.busy), '0);

        // T1
        issue(2'd0, 32'd7, -32'sd3);
        wait_done(cyc, bc);
        chk("t1_latency", W'(cyc), 32'd34);
        chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
        chk("t1_lo", bus.lo, 32'hFFFF_FFEB);
        chk("t1_model_lo", m_lo, 32'hFFFF_FFEB);

        // T2, started in the done cycle of T1
        issue(2'd0, INT_MIN, INT_MIN);
        wait_done(cyc, bc);
        chk("t2_busy_cycles", W'(bc), 32'd33);
        chk("t2_hi", bus.hi, 32'h4000_0000);
        chk("t2_lo", bus.lo, 32'h0000_0000);

        // T3
        issue(2'd1, -32'sd7, 32'd2);
        wait_done(cyc, bc);
        chk("t3a_lo", bus.lo, 32'hFFFF_FFFD);
        chk("t3a_hi", bus.hi, 32'hFFFF_FFFF);
        issue(2'd1, INT_MIN, 32'hFFFF_FFFF);
        wait_done(cyc, bc);
        chk("t3b_lo", bus.lo, 32'h8000_0000);
        chk("t3b_hi", bus.hi, 32'h0000_0000);
        chk("t3b_model_lo", m_lo, 32'h8000_0000);

        // T4
        issue(2'd1, 32'd5, 32'd0);
        wait_done(cyc, bc);
        chk("t4_latency", W'(cyc), 32'd34);
        chk("t4_lo", bus.lo, 32'hFFFF_FFFF);
        chk("t4_hi", bus.hi, 32'h0000_0005);

        // T6: reset mid-RUN drops the op
        @(negedge clk);
        issue(2'd0, 32'd5, 32'd6);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", W'(bus.busy), '0);
        chk("t6_hi", bus.hi, '0);
        chk("t6_lo", bus.lo, '0);
        bc = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) bc++;
        end
        chk("t6_no_done", W'(bc), '0);

        // T5: start while busy is ignored, then ZERO
        issue(2'd0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1 bus.start = 1'b1; bus.mdluOp = 2'd1; bus.opA = 32'd9; bus.opB = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(cyc, bc);
        chk("t5_hi", bus.hi, 32'h0);
        chk("t5_lo", bus.lo, 32'hC);
        issue(2'd2, 32'd1, 32'd1);
        wait_done(cyc, bc);
        chk("t5_zero_latency", W'(cyc), 32'd1);
        chk("t5_zero_lo", bus.lo, 32'h0);

        // Reserved op: nothing happens
        @(negedge clk);
        issue(2'd3, 32'd11, 32'd13);
        @(negedge clk);
        chk("op3_done", W'(bus.done), '0);
        chk("op3_busy", W'(bus.busy), '0);

        // Mixed random and corner operands
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] a, b;
            logic [W-1:0] corners [5];
            corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, INT_MIN, INT_MAX};
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            if ($urandom_range(0, 2) == 0) b = W'($signed(W'($urandom_range(0, 20))) - 10);
            issue(2'($urandom_range(0, 1)), a, b);
            wait_done(cyc, bc);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
